// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned RF_A_WIDTH = 5;
  localparam int unsigned RF_D_WIDTH = 32;

  localparam logic [RF_A_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_A_WIDTH-1:0] rd;
    logic [RF_D_WIDTH-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Write-back request channel: valid/ready handshake carrying a destination register and data.
interface regfile_wb_queue_if #(
  parameter int unsigned A_WIDTH = regfile_pkg::RF_A_WIDTH,
  parameter int unsigned D_WIDTH = regfile_pkg::RF_D_WIDTH
);

  logic               valid;
  logic               ready;
  logic [A_WIDTH-1:0] rd;
  logic [D_WIDTH-1:0] wd;

  modport master (output valid, output rd, output wd, input ready);
  modport slave  (input valid, input rd, input wd, output ready);

endinterface

// File: rtl/wb_fifo_mem.sv
// Entry storage for the write-back queue: two write ports, one head read port,
// plus a flat view of every slot for the lookup search.
module wb_fifo_mem
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we0,
  input  logic [PTR_W-1:0] i_wa0,
  input  wb_entry_t        i_wd0,
  input  logic             i_we1,
  input  logic [PTR_W-1:0] i_wa1,
  input  wb_entry_t        i_wd1,
  input  logic [PTR_W-1:0] i_ra,
  output wb_entry_t        o_rdata_c,
  output wb_entry_t        o_ent_c [DEPTH]
);

  wb_entry_t r_mem [DEPTH];

  // Port 1 only fires alongside port 0 at a different slot, so no write collision.
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_wa0] <= i_wd0;
    if (i_we1) r_mem[i_wa1] <= i_wd1;
  end

  assign o_rdata_c = r_mem[i_ra];
  assign o_ent_c   = r_mem;

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of the register file write port, merging
// load and ALU results and exposing a youngest-match bypass lookup.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int unsigned A_WIDTH = RF_A_WIDTH,
  parameter int unsigned D_WIDTH = RF_D_WIDTH,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_wb_queue_if.slave            mem,
  regfile_wb_queue_if.slave            alu,
  output logic                         WE3,
  output logic [A_WIDTH-1:0]           AD3,
  output logic [D_WIDTH-1:0]           WD3,
  input  logic [A_WIDTH-1:0]           q_ad,
  output logic                         q_hit,
  output logic [D_WIDTH-1:0]           q_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned CNTX_W = CNT_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  wb_entry_t        w_mem_ent;
  wb_entry_t        w_alu_ent;
  wb_entry_t        w_head_ent;
  wb_entry_t        w_ent [DEPTH];
  wb_entry_t        w_wd0;
  logic             w_mem_ready;
  logic             w_alu_ready;
  logic             w_mem_enq;
  logic             w_alu_enq;
  logic             w_deq;
  logic             w_we0;
  logic             w_we1;
  logic [1:0]       w_n_enq;
  logic [PTR_W-1:0] w_wa1;

  // Readiness looks only at registered occupancy; the ALU slot is reserved
  // behind any valid load so the load always keeps its older position.
  always_comb begin
    w_mem_ready = (r_count < CNT_W'(DEPTH));
    w_alu_ready = ((CNTX_W'(r_count) + CNTX_W'(mem.valid)) < CNTX_W'(DEPTH));

    w_mem_ent.rd = RF_A_WIDTH'(mem.rd);
    w_mem_ent.wd = RF_D_WIDTH'(mem.wd);
    w_alu_ent.rd = RF_A_WIDTH'(alu.rd);
    w_alu_ent.wd = RF_D_WIDTH'(alu.wd);

    // Writes to x0 finish the handshake but never occupy a slot.
    w_mem_enq = mem.valid && w_mem_ready && (w_mem_ent.rd != REG_ZERO);
    w_alu_enq = alu.valid && w_alu_ready && (w_alu_ent.rd != REG_ZERO);
    w_n_enq   = 2'(w_mem_enq) + 2'(w_alu_enq);
    w_deq     = (r_count != '0);

    w_we0 = w_mem_enq || w_alu_enq;
    w_wd0 = w_mem_enq ? w_mem_ent : w_alu_ent;
    w_we1 = w_mem_enq && w_alu_enq;
    w_wa1 = r_tail + PTR_W'(1);
  end

  assign mem.ready = w_mem_ready;
  assign alu.ready = w_alu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_tail  <= r_tail + PTR_W'(w_n_enq);
      r_count <= r_count + CNT_W'(w_n_enq) - CNT_W'(w_deq);
    end
  end

  wb_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .i_we0     (w_we0),
    .i_wa0     (r_tail),
    .i_wd0     (w_wd0),
    .i_we1     (w_we1),
    .i_wa1     (w_wa1),
    .i_wd1     (w_alu_ent),
    .i_ra      (r_head),
    .o_rdata_c (w_head_ent),
    .o_ent_c   (w_ent)
  );

  assign WE3   = (r_count != '0);
  assign AD3   = A_WIDTH'(w_head_ent.rd);
  assign WD3   = D_WIDTH'(w_head_ent.wd);
  assign count = r_count;
  assign empty = (r_count == '0);

  // Walk oldest to youngest so the last match wins; the head entry is still
  // pending until the edge, so it takes part in the search.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((i < 32'(r_count)) && (q_ad != '0) &&
          (w_ent[PTR_W'(r_head + PTR_W'(i))].rd == RF_A_WIDTH'(q_ad))) begin
        q_hit  = 1'b1;
        q_data = D_WIDTH'(w_ent[PTR_W'(r_head + PTR_W'(i))].wd);
      end
    end
  end

endmodule
